job_encoder: RTL
================

Name: job_encoder

Overview:
- Return-path counterpart of the job decoder. Accepts completed-job records from two plane-side channels and round-robin arbitrates between them.
- Packs each record's host ID, plane ID and metadata back into the 128-bit command-info layout: host ID at CDW12 (bit 64), plane ID at CDW13 (bit 96).
- Presents the packed word on a valid/ready output towards the host-side queue.

Parameters:
- MAX_HOST_NUMBER, `MAX_HOST_NUMBER, number of hosts.
- MAX_PLANE_NUMBER, `MAX_PLANE_NUMBER, number of planes.
- HOST_ID_BIT_WIDTH, $clog2(MAX_HOST_NUMBER), host ID width.
- PLANE_ID_BIT_WIDTH, $clog2(MAX_PLANE_NUMBER), plane ID width.
- INFO_DATA_BIT_WIDTH, 128, packed info word width.
- META_DATA_BIT_WIDTH, INFO_DATA_BIT_WIDTH-HOST_ID_BIT_WIDTH-1, metadata width (all bits except host field and bit 127).
- JOB_CNT_WIDTH, 16, posted-job counter width.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid_0  in  1  channel 0 record valid.
- o_ready_0  out  1  channel 0 accepted this cycle.
- i_host_id_0  in  HOST_ID_BIT_WIDTH  channel 0 host ID.
- i_plane_id_0  in  PLANE_ID_BIT_WIDTH  channel 0 plane ID.
- i_meta_data_0  in  META_DATA_BIT_WIDTH  channel 0 metadata.
- i_valid_1, o_ready_1, i_host_id_1, i_plane_id_1, i_meta_data_1: same as channel 0, for channel 1.
- o_output_info  out  INFO_DATA_BIT_WIDTH  packed info word.
- o_info_valid  out  1  packed word valid.
- i_info_ready  in  1  downstream accepts.
- o_busy  out  1  FSM not in IDLE.
- o_job_count  out  JOB_CNT_WIDTH  number of words posted.

Behaviour:
- Reset values:
  - FSM = IDLE (one-hot, bit IDLE set).
  - o_output_info = 0; o_info_valid = 0; o_ready_0/1 = 0; o_busy = 0; o_job_count = 0.
  - Round-robin pointer = channel 0.
- FSM states: IDLE, CAPTURE, PACK, POST. All transitions are unconditional except those listed below.
- IDLE:
  - o_ready_x = 1 combinationally for the granted channel only; grant goes to a channel whose i_valid_x = 1.
  - Both valid: grant the pointer channel. One valid: grant that channel regardless of the pointer.
  - Transfer occurs on i_valid_x & o_ready_x. Fields are latched at that edge; the pointer flips to the other channel; next state is CAPTURE.
  - No valid: stay in IDLE.
- CAPTURE:
  - Registers the latched channel's fields into the internal record.
  - Both o_ready outputs = 0 in every non-IDLE state.
- PACK builds o_output_info:
  - [63:0] = meta[63:0].
  - [64 +: HW] = host_id.
  - [126 : 64+HW] = meta[META-1:64].
  - [96 +: PW] is then overwritten by plane_id.
  - [127] = 1 (completion flag).
- POST:
  - o_info_valid = 1; o_output_info held stable until i_info_ready = 1.
  - On the handshake: o_info_valid drops next cycle, o_job_count increments (wraps at 2^JOB_CNT_WIDTH − 1 → 0), state returns to IDLE.
- Latency:
  - Accept edge N → o_info_valid high from cycle N+3.
  - Minimum 4 cycles per job, i.e. at most one job in flight; no pipelining.
- Stalls:
  - i_info_ready held low keeps POST indefinitely; no new accepts during the stall.
  - i_info_ready high on the first POST cycle completes in one cycle.
- Simultaneous events:
  - A new i_valid arriving in the same cycle as the POST handshake is not accepted until IDLE (next cycle).
- Reset mid-operation: any in-flight job is dropped with no output; all registers return to reset values.
- Field truncation: inputs are used at their declared widths; no range checking of ID values.

Optional Feature:
- Macro: JOB_ENCODER_PARITY_EN.
- Defined: bit [127] = even parity (XOR) of bits [126:0] of the packed word, computed in PACK.
- Undefined: bit [127] = constant 1'b1.

Decomposition:
- Shared package/defines:
  - HOST_ID_START_OFFSET (64), PLANE_ID_START_OFFSET (96), completion flag bit position (127).
  - FSM state indices, shared with the decoder.
- One natural sub-module: job_rr_arbiter_2. Two-request round-robin arbiter with pointer register; outputs a one-hot grant and an update strobe.

Test Plan:
- Single job ch0 (host=2, plane=5, meta=all-ones pattern) → o_info_valid at N+3; [64+:HW]=2, [96+:PW]=5, [127]=1; o_job_count=1.
- Both channels valid continuously, i_info_ready=1 → grants alternate 0,1,0,1 starting with ch0 after reset; each word carries its own channel's IDs.
- i_info_ready held low 10 cycles in POST → o_output_info stable; o_ready_0/1 stay 0; count increments only on release.
- Reset asserted during PACK → no o_info_valid; all outputs 0; pointer back to ch0; next job packs correctly.
- Loopback: encoder output fed to job decoder → decoded host ID, plane ID and metadata (excluding the plane-overlapped bits) equal the original inputs for 1000 random jobs.
- With JOB_ENCODER_PARITY_EN, meta=0, host=1, plane=0 → [127]=1; with host=3 → [127]=0.

Source files
------------

// File: rtl/job_encoder_pkg.sv
// Shared definitions for the job encoder: command-info field offsets and the
// one-hot FSM state encoding (state indices are shared with the job decoder).
// Host/plane counts come from `MAX_HOST_NUMBER / `MAX_PLANE_NUMBER; defaults below.
`ifndef MAX_HOST_NUMBER
`define MAX_HOST_NUMBER 4
`endif
`ifndef MAX_PLANE_NUMBER
`define MAX_PLANE_NUMBER 8
`endif

package job_encoder_pkg;

  // Command-info layout: host ID at CDW12, plane ID at CDW13, completion flag on top.
  localparam int HOST_ID_START_OFFSET  = 64;
  localparam int PLANE_ID_START_OFFSET = 96;
  localparam int COMPLETION_FLAG_BIT   = 127;

  // One-hot state bit positions.
  localparam int ST_IDLE_IDX    = 0;
  localparam int ST_CAPTURE_IDX = 1;
  localparam int ST_PACK_IDX    = 2;
  localparam int ST_POST_IDX    = 3;

  typedef enum logic [3:0] {
    StIdle    = 4'b0001,
    StCapture = 4'b0010,
    StPack    = 4'b0100,
    StPost    = 4'b1000
  } job_state_e;

endpackage

// File: rtl/job_rr_arbiter_2.sv
// Two-request round-robin arbiter. The pointer names the channel that wins a tie;
// after every grant it moves to the channel that was not served.
module job_rr_arbiter_2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant,
  output logic       o_update
);

  logic ptr_q, ptr_d;

  // Grant selection: a lone requester always wins, a tie goes to the pointer
  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      unique case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = ptr_q ? 2'b10 : 2'b01;
        default: o_grant = 2'b00;
      endcase
    end
    o_update = |o_grant;
    ptr_d    = o_update ? o_grant[0] : ptr_q;
  end

  // Pointer register, starts on channel 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/job_encoder.sv
// Job encoder: arbitrates completed-job records from two plane-side channels and
// packs host ID, plane ID and metadata into the 128-bit command-info word.
// Optional: define JOB_ENCODER_PARITY_EN to make bit 127 the XOR of bits 126:0
// instead of a constant completion flag.
module job_encoder
  import job_encoder_pkg::*;
#(
  parameter int MAX_HOST_NUMBER     = `MAX_HOST_NUMBER,
  parameter int MAX_PLANE_NUMBER    = `MAX_PLANE_NUMBER,
  parameter int HOST_ID_BIT_WIDTH   = $clog2(MAX_HOST_NUMBER),
  parameter int PLANE_ID_BIT_WIDTH  = $clog2(MAX_PLANE_NUMBER),
  parameter int INFO_DATA_BIT_WIDTH = 128,
  parameter int META_DATA_BIT_WIDTH = INFO_DATA_BIT_WIDTH - HOST_ID_BIT_WIDTH - 1,
  parameter int JOB_CNT_WIDTH       = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid_0,
  output logic                           o_ready_0,
  input  logic [HOST_ID_BIT_WIDTH-1:0]   i_host_id_0,
  input  logic [PLANE_ID_BIT_WIDTH-1:0]  i_plane_id_0,
  input  logic [META_DATA_BIT_WIDTH-1:0] i_meta_data_0,
  input  logic                           i_valid_1,
  output logic                           o_ready_1,
  input  logic [HOST_ID_BIT_WIDTH-1:0]   i_host_id_1,
  input  logic [PLANE_ID_BIT_WIDTH-1:0]  i_plane_id_1,
  input  logic [META_DATA_BIT_WIDTH-1:0] i_meta_data_1,
  output logic [INFO_DATA_BIT_WIDTH-1:0] o_output_info,
  output logic                           o_info_valid,
  input  logic                           i_info_ready,
  output logic                           o_busy,
  output logic [JOB_CNT_WIDTH-1:0]       o_job_count
);

  job_state_e state_q, state_d;

  logic [1:0] grant;
  logic       accept;

  logic [HOST_ID_BIT_WIDTH-1:0]   lat_host_q,  rec_host_q;
  logic [PLANE_ID_BIT_WIDTH-1:0]  lat_plane_q, rec_plane_q;
  logic [META_DATA_BIT_WIDTH-1:0] lat_meta_q,  rec_meta_q;
  logic [INFO_DATA_BIT_WIDTH-1:0] info_q, info_packed;
  logic [JOB_CNT_WIDTH-1:0]       job_cnt_q;

  // Arbiter only looks at requests while idle, so grant doubles as ready
  job_rr_arbiter_2 u_arb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (state_q == StIdle),
    .i_req    ({i_valid_1, i_valid_0}),
    .o_grant  (grant),
    .o_update (accept)
  );

  assign o_ready_0     = grant[0];
  assign o_ready_1     = grant[1];
  assign o_output_info = info_q;
  assign o_info_valid  = state_q[ST_POST_IDX];
  assign o_busy        = ~state_q[ST_IDLE_IDX];
  assign o_job_count   = job_cnt_q;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: one pass through CAPTURE and PACK per job, POST waits for the host queue
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q[ST_IDLE_IDX]:    if (accept) state_d = StCapture;
      state_q[ST_CAPTURE_IDX]: state_d = StPack;
      state_q[ST_PACK_IDX]:    state_d = StPost;
      state_q[ST_POST_IDX]:    if (i_info_ready) state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
  end

  // Latch the granted channel's fields on the accept edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lat_host_q  <= '0;
      lat_plane_q <= '0;
      lat_meta_q  <= '0;
    end else if (accept) begin
      lat_host_q  <= grant[1] ? i_host_id_1   : i_host_id_0;
      lat_plane_q <= grant[1] ? i_plane_id_1  : i_plane_id_0;
      lat_meta_q  <= grant[1] ? i_meta_data_1 : i_meta_data_0;
    end
  end

  // Move the latched fields into the internal record during CAPTURE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rec_host_q  <= '0;
      rec_plane_q <= '0;
      rec_meta_q  <= '0;
    end else if (state_q == StCapture) begin
      rec_host_q  <= lat_host_q;
      rec_plane_q <= lat_plane_q;
      rec_meta_q  <= lat_meta_q;
    end
  end

  // Command-info layout; the plane ID deliberately overwrites metadata bits at CDW13
  always_comb begin
    info_packed = '0;
    info_packed[HOST_ID_START_OFFSET-1:0] = rec_meta_q[HOST_ID_START_OFFSET-1:0];
    info_packed[HOST_ID_START_OFFSET +: HOST_ID_BIT_WIDTH] = rec_host_q;
    info_packed[COMPLETION_FLAG_BIT-1:HOST_ID_START_OFFSET+HOST_ID_BIT_WIDTH] =
      rec_meta_q[META_DATA_BIT_WIDTH-1:HOST_ID_START_OFFSET];
    info_packed[PLANE_ID_START_OFFSET +: PLANE_ID_BIT_WIDTH] = rec_plane_q;
`ifdef JOB_ENCODER_PARITY_EN
    info_packed[COMPLETION_FLAG_BIT] = ^info_packed[COMPLETION_FLAG_BIT-1:0];
`else
    info_packed[COMPLETION_FLAG_BIT] = 1'b1;
`endif
  end

  // Output word register, loaded in PACK and held through POST
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      info_q <= '0;
    end else if (state_q == StPack) begin
      info_q <= info_packed;
    end
  end

  // Posted-job counter, bumps on the POST handshake and wraps naturally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      job_cnt_q <= '0;
    end else if ((state_q == StPost) && i_info_ready) begin
      job_cnt_q <= job_cnt_q + JOB_CNT_WIDTH'(1);
    end
  end

endmodule
